// File: rtl/pdm_frame_sched.sv
// Stereo PDM window sequencer: strobes window end, captures L/R one cycle later and
// serializes them on a valid/ready port; frames arriving while busy are dropped and counted.
module pdm_frame_sched #(
    parameter int WIN_LEN = 1134,
    parameter int DW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [1:0]    i_ch_mask,
    input  logic [DW-1:0] i_lft_in,
    input  logic [DW-1:0] i_rght_in,
    output logic          o_win_end,
    output logic [DW-1:0] o_smp_data,
    output logic          o_smp_chan,
    output logic          o_smp_vld,
    input  logic          i_smp_rdy,
    output logic          o_overrun,
    output logic [7:0]    o_drop_cnt,
    input  logic          i_clr_ovr
);
    localparam int CW = $clog2(WIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_cap_pend;
    logic [DW-1:0] r_hold_l;
    logic [DW-1:0] r_hold_r;
    logic [1:0]    r_mask_q;
    logic [DW-1:0] r_smp_data;
    logic          r_smp_chan;
    logic          r_overrun;
    logic [7:0]    r_drop_cnt;

    logic          w_hs;
    logic          w_last_hs;
    logic          w_accept;
    logic          w_drop;

    assign o_win_end  = i_en && (r_cnt == LAST);
    assign o_smp_vld  = (r_state != IDLE);
    assign o_smp_data = r_smp_data;
    assign o_smp_chan = r_smp_chan;
    assign o_overrun  = r_overrun;
    assign o_drop_cnt = r_drop_cnt;

    // A frame may start in the same cycle the previous frame's final sample is taken.
    assign w_hs      = o_smp_vld && i_smp_rdy;
    assign w_last_hs = w_hs && ((r_state == SEND_R) || (r_state == SEND_L && !r_mask_q[1]));
    assign w_accept  = r_cap_pend && ((r_state == IDLE) || w_last_hs);
    assign w_drop    = r_cap_pend && !w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
        end else begin
            r_cap_pend <= o_win_end;
            if (!i_en || r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = IDLE;
            SEND_L:  if (w_hs) w_state_nxt = r_mask_q[1] ? SEND_R : IDLE;
            SEND_R:  if (w_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            if (i_ch_mask[0]) begin
                w_state_nxt = SEND_L;
            end else if (i_ch_mask[1]) begin
                w_state_nxt = SEND_R;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_mask_q   <= '0;
            r_smp_data <= '0;
            r_smp_chan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hold_l <= i_lft_in;
                r_hold_r <= i_rght_in;
                r_mask_q <= i_ch_mask;
            end
            // Reloading the same hold value while stalled keeps the port stable.
            if (w_state_nxt == SEND_L) begin
                r_smp_data <= w_accept ? i_lft_in : r_hold_l;
                r_smp_chan <= 1'b0;
            end else if (w_state_nxt == SEND_R) begin
                r_smp_data <= w_accept ? i_rght_in : r_hold_r;
                r_smp_chan <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun  <= 1'b1;
            if (i_clr_ovr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (i_clr_ovr) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_pdm_frame_sched.sv
// Randomized bench for pdm_frame_sched: a sample-level frame model feeds a scoreboard
// that a decoupled monitor drains on every valid/ready handshake.
module tb_pdm_frame_sched;
    localparam int WIN_LEN = 8;
    localparam int DW      = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    ch_mask = 2'b00;
    logic [DW-1:0] lft_in = '0;
    logic [DW-1:0] rght_in = '0;
    logic          smp_rdy = 1'b0;
    logic          clr_ovr = 1'b0;
    logic          win_end;
    logic [DW-1:0] smp_data;
    logic          smp_chan;
    logic          smp_vld;
    logic          overrun;
    logic [7:0]    drop_cnt;

    pdm_frame_sched #(.WIN_LEN(WIN_LEN), .DW(DW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_ch_mask  (ch_mask),
        .i_lft_in   (lft_in),
        .i_rght_in  (rght_in),
        .o_win_end  (win_end),
        .o_smp_data (smp_data),
        .o_smp_chan (smp_chan),
        .o_smp_vld  (smp_vld),
        .i_smp_rdy  (smp_rdy),
        .o_overrun  (overrun),
        .o_drop_cnt (drop_cnt),
        .i_clr_ovr  (clr_ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          chan;
        logic [DW-1:0] data;
    } smp_t;

    smp_t exp_q[$];
    smp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Frame model: window position, pending capture, samples still owed, overrun state.
    int   mcnt  = 0;
    bit   mcap  = 1'b0;
    int   outst = 0;
    bit   movr  = 1'b0;
    int   mdrop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && smp_vld && smp_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got chan %0d data %0h with no sample owed at %0t",
                         smp_chan, smp_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("smp_chan", {31'd0, smp_chan}, {31'd0, mon_e.chan});
                chk("smp_data", {16'd0, smp_data}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic cycle(input bit e, input bit r, input logic [1:0] m, input bit c,
                         input logic [DW-1:0] l, input logic [DW-1:0] rr);
        bit w;
        int after;
        @(posedge clk);
        #1;
        chk("smp_vld", {31'd0, smp_vld}, (outst > 0) ? 32'd1 : 32'd0);
        chk("overrun", {31'd0, overrun}, {31'd0, movr});
        chk("drop_cnt", {24'd0, drop_cnt}, mdrop);
        en = e; smp_rdy = r; ch_mask = m; clr_ovr = c; lft_in = l; rght_in = rr;
        #1;
        w = e && (mcnt == WIN_LEN - 1);
        chk("win_end", {31'd0, win_end}, {31'd0, w});
        after = outst - ((outst > 0 && r) ? 1 : 0);
        if (mcap && after == 0) begin
            if (m[0]) exp_q.push_back({1'b0, l});
            if (m[1]) exp_q.push_back({1'b1, rr});
            after = int'(m[0]) + int'(m[1]);
            if (c) begin movr = 1'b0; mdrop = 0; end
        end else if (mcap) begin
            movr  = 1'b1;
            mdrop = c ? 1 : ((mdrop < 255) ? mdrop + 1 : 255);
        end else if (c) begin
            movr  = 1'b0;
            mdrop = 0;
        end
        outst = after;
        mcap  = w;
        mcnt  = e ? ((mcnt == WIN_LEN - 1) ? 0 : mcnt + 1) : 0;
    endtask

    task automatic rcycle(input bit e, input bit r, input logic [1:0] m, input bit c);
        cycle(e, r, m, c, DW'($urandom), DW'($urandom));
    endtask

    initial begin
        #1;
        chk("rst_vld", {31'd0, smp_vld}, 32'd0);
        chk("rst_win_end", {31'd0, win_end}, 32'd0);
        chk("rst_data", {16'd0, smp_data}, 32'd0);
        chk("rst_chan", {31'd0, smp_chan}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Steady stream, fixed data, always ready.
        for (int i = 0; i < 40; i++) cycle(1, 1, 2'b11, 0, 16'h0123, 16'h0456);

        // Back-pressure: hold the port for 20 cycles from the first valid sample.
        for (int i = 0; i < 20 && outst != 2; i++) cycle(1, 1, 2'b11, 0, 16'h0123, 16'h0456);
        for (int i = 0; i < 20; i++) cycle(1, 0, 2'b11, 0, 16'h0AAA, 16'h0BBB);
        chk("bp_drop_cnt_model", mdrop, 32'd2);
        for (int i = 0; i < 10; i++) cycle(1, 1, 2'b11, 0, 16'h0123, 16'h0456);

        // Asynchronous reset while the left sample is on the port.
        for (int i = 0; i < 20 && outst != 2; i++) rcycle(1, 0, 2'b11, 0);
        @(posedge clk); #3;
        rst = 1'b1; en = 1'b0; smp_rdy = 1'b0; clr_ovr = 1'b0;
        #1;
        chk("arst_vld", {31'd0, smp_vld}, 32'd0);
        chk("arst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        mcnt = 0; mcap = 0; outst = 0; movr = 0; mdrop = 0;
        @(posedge clk); #1; rst = 1'b0;

        // Final SEND_R handshake lands exactly in the capture cycle.
        for (int i = 0; i < 20 && outst != 2; i++) rcycle(1, 0, 2'b11, 0);
        rcycle(1, 1, 2'b11, 0);
        for (int i = 0; i < 20 && !(mcap && outst == 1); i++) rcycle(1, 0, 2'b11, 0);
        rcycle(1, 1, 2'b11, 0);
        for (int i = 0; i < 10; i++) rcycle(1, 1, 2'b11, 0);

        // Channel masks: right only, then none.
        for (int i = 0; i < 40; i++) rcycle(1, 1, 2'b10, 0);
        for (int i = 0; i < 40; i++) rcycle(1, ($urandom % 2) == 1, 2'b00, 0);

        // Drop enable at cnt=5, then re-raise.
        for (int i = 0; i < 20 && mcnt != 5; i++) rcycle(1, 1, 2'b11, 0);
        for (int i = 0; i < 4; i++) rcycle(0, 1, 2'b11, 0);
        for (int i = 0; i < 20; i++) rcycle(1, 1, 2'b11, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            rcycle(($urandom % 40) != 0, ($urandom % 4) != 0, 2'($urandom), ($urandom % 64) == 0);
        for (int i = 0; i < 12; i++) rcycle(1, 1, 2'b11, 1);

        // Saturation: port stuck for over 300 windows.
        for (int i = 0; i < 310 * WIN_LEN; i++) rcycle(1, 0, 2'b11, 0);
        chk("sat_model", mdrop, 32'd255);
        for (int i = 0; i < 20 && mcap; i++) rcycle(1, 0, 2'b11, 0);
        rcycle(1, 0, 2'b11, 1);
        rcycle(1, 0, 2'b11, 0);
        for (int i = 0; i < 20 && !mcap; i++) rcycle(1, 0, 2'b11, 0);
        rcycle(1, 0, 2'b11, 1);
        rcycle(1, 0, 2'b11, 0);
        chk("clr_vs_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        chk("clr_vs_drop_ovr", {31'd0, overrun}, 32'd1);

        // Drain everything still owed.
        for (int i = 0; i < 20; i++) rcycle(0, 1, 2'b11, 0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_frame_sched.md
Name: pdm_frame_sched

Overview:
- Window sequencer and output arbiter for the stereo PDM decode path.
- Generates the decimation-window end strobe that closes each accumulation window in the decoder.
- Captures the decoder's left/right 16-bit results one cycle later.
- Serializes both channels onto one valid/ready sample port feeding the shared downstream filter engine; flags frames dropped by back-pressure.

Parameters:
WIN_LEN  1134  window period in clk cycles (legal range 4..2047)
DW  16  sample width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable for window counter
ch_mask  in  2  bit0 = left enabled, bit1 = right enabled; sampled at capture
lft_in  in  DW  decoder left result
rght_in  in  DW  decoder right result
win_end  out  1  one-cycle pulse closing the current window (to decoder)
smp_data  out  DW  sample to shared engine
smp_chan  out  1  0 = left, 1 = right
smp_vld  out  1  sample valid
smp_rdy  in  1  engine ready
overrun  out  1  sticky: frame dropped
drop_cnt  out  8  saturating count of dropped frames
clr_ovr  in  1  clears overrun and drop_cnt

Behaviour:
- Reset, asserted asynchronously:
  - Window counter cnt (width $clog2(WIN_LEN)) = 0; cap_pend = 0; state = IDLE.
  - Outputs: win_end = 0, smp_vld = 0, smp_data = 0, smp_chan = 0, overrun = 0, drop_cnt = 0.
- Window counter:
  - When en = 1: cnt increments each cycle and wraps WIN_LEN-1 -> 0.
  - win_end is combinational and asserts while en = 1 and cnt == WIN_LEN-1, so it pulses once per WIN_LEN cycles.
  - When en = 0: cnt is held at 0, cap_pend is cleared, and win_end = 0. Any transfer already in flight completes normally.
- Capture:
  - cap_pend is a register that loads win_end; it marks the capture cycle one cycle after win_end.
  - In the capture cycle, when capture is accepted: hold_l <= lft_in, hold_r <= rght_in, mask_q <= ch_mask.
- FSM states: IDLE, SEND_L, SEND_R.
  - IDLE: on accepted capture, go to SEND_L if ch_mask[0], else SEND_R if ch_mask[1], else stay IDLE (no output).
  - SEND_L: smp_vld = 1, smp_chan = 0, smp_data = hold_l. On smp_vld & smp_rdy, go to SEND_R if mask_q[1], else IDLE.
  - SEND_R: smp_vld = 1, smp_chan = 1, smp_data = hold_r. On handshake, go to IDLE.
  - smp_data and smp_chan are registered and stay stable while smp_vld = 1 and smp_rdy = 0; smp_vld never drops without a handshake.
  - In IDLE: smp_vld = 0; smp_data and smp_chan hold their last values.
- Latency: win_end at cycle N -> capture at N+1 -> smp_vld = 1 at N+2.
- Capture acceptance and overrun:
  - A capture is accepted if state == IDLE, or if the final handshake of the current frame occurs in the same cycle. In the latter case the FSM goes directly to the first enabled channel of the new frame; no overrun.
  - Otherwise the capture is dropped:
    - hold registers and mask_q are unchanged;
    - overrun <= 1;
    - drop_cnt increments, saturating at 255.
- clr_ovr: clears overrun and drop_cnt. If a drop occurs in the same cycle, the drop wins: overrun = 1, drop_cnt = 1.
- ch_mask changes between captures do not affect a frame in progress.

Test Plan:
- WIN_LEN=8, en=1 from reset release, smp_rdy=1, ch_mask=2'b11, lft_in=16'h0123, rght_in=16'h0456:
  - win_end pulses on every 8th cycle (cnt=7);
  - two cycles after each pulse: smp_vld with chan 0 / data 0x0123, then next cycle chan 1 / data 0x0456;
  - overrun stays 0.
- Back-pressure, smp_rdy=0 for 20 cycles from first smp_vld:
  - smp_data = 0x0123 and smp_chan = 0 stay stable throughout;
  - the two subsequent captures are dropped, giving overrun = 1 and drop_cnt = 2;
  - after smp_rdy=1, the original frame completes with its original values.
- Handshake of SEND_R coincident with capture (smp_rdy asserted exactly in the capture cycle) -> new frame accepted, SEND_L next cycle with new lft_in, overrun = 0.
- ch_mask=2'b10 -> only chan 1 samples emitted; ch_mask=2'b00 -> smp_vld never asserts while win_end continues pulsing.
- Timing of en and reset:
  - en dropped at cnt=5 -> no win_end, cnt=0; en re-raised -> first win_end exactly WIN_LEN cycles later.
  - rst asserted mid SEND_L -> smp_vld = 0, state IDLE, and drop_cnt = 0 immediately (asynchronous).
- 300 forced drops -> drop_cnt saturates at 255; clr_ovr pulse -> overrun = 0, drop_cnt = 0; clr_ovr coincident with a drop -> overrun = 1, drop_cnt = 1.
